// File: rtl/conv_relu_pool.sv
// conv_relu_pool: strips row-wrap samples from the conv raster stream,
// applies optional ReLU and 2x2 stride-2 max pooling into a result BRAM.
module conv_relu_pool #(
   parameter int N          = 16,
   parameter int DATA_WIDTH = 16,
   parameter int K_SIZE     = 3,
   parameter int RELU_EN    = 1,
   localparam int OW = N - K_SIZE + 1,
   localparam int PW = OW / 2,
   localparam int AW = (PW * PW > 1) ? $clog2(PW * PW) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] data_i,
   input  logic                         valid_i,
   output logic signed [DATA_WIDTH-1:0] pool_o,
   output logic                         pool_valid_o,
   output logic [AW-1:0]                pool_addr_o,
   output logic                         done_o,
   output logic                         busy_o
);

   localparam int CW  = $clog2(N);
   localparam int PIW = (PW > 1) ? $clog2(PW) : 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(N - 1);
   localparam logic [CW-1:0] OUT_LAST  = CW'(OW - 1);
   localparam logic [CW-1:0] POOL_SPAN = CW'(2 * PW);
   localparam logic [AW-1:0] ADDR_LAST = AW'(PW * PW - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state;
   logic [CW-1:0]           col_cnt;
   logic [CW-1:0]           row_cnt;
   logic [AW-1:0]           addr_cnt;
   logic signed [DATA_WIDTH-1:0] h_reg;
   logic signed [DATA_WIDTH-1:0] line_buf [PW];

   logic signed [DATA_WIDTH-1:0] x_relu;
   logic signed [DATA_WIDTH-1:0] hmax;
   logic signed [DATA_WIDTH-1:0] lb_rd;
   logic signed [DATA_WIDTH-1:0] vmax;
   logic [PIW-1:0]          hidx;
   logic                    keep;
   logic                    last;

   assign busy_o = (state == RUN);

   always_comb begin
      x_relu = data_i;
      if (RELU_EN != 0 && data_i < 0)
         x_relu = '0;
      hmax  = (x_relu > h_reg) ? x_relu : h_reg;
      hidx  = PIW'(col_cnt >> 1);
      lb_rd = line_buf[hidx];
      vmax  = (hmax > lb_rd) ? hmax : lb_rd;
      // Row-wrap columns and an odd trailing row/col fall outside the span
      keep  = (col_cnt < POOL_SPAN) && (row_cnt < POOL_SPAN);
      last  = (row_cnt == OUT_LAST) && (col_cnt == OUT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         col_cnt      <= '0;
         row_cnt      <= '0;
         addr_cnt     <= '0;
         h_reg        <= '0;
         pool_o       <= '0;
         pool_valid_o <= 1'b0;
         pool_addr_o  <= '0;
         done_o       <= 1'b0;
      end else begin
         pool_valid_o <= 1'b0;
         done_o       <= 1'b0;
         if (valid_i) begin
            state <= last ? IDLE : RUN;
            if (last) begin
               col_cnt <= '0;
               row_cnt <= '0;
            end else if (col_cnt == COL_LAST) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
            if (keep) begin
               if (!col_cnt[0]) begin
                  h_reg <= x_relu;
               end else if (row_cnt[0]) begin
                  pool_o       <= vmax;
                  pool_valid_o <= 1'b1;
                  pool_addr_o  <= addr_cnt;
                  if (addr_cnt == ADDR_LAST) begin
                     done_o   <= 1'b1;
                     addr_cnt <= '0;
                  end else begin
                     addr_cnt <= addr_cnt + 1'b1;
                  end
               end
            end
         end
      end
   end

   // Even pooled rows park their horizontal max until the odd row arrives
   always_ff @(posedge clk) begin
      if (valid_i && keep && col_cnt[0] && !row_cnt[0])
         line_buf[hidx] <= hmax;
   end

endmodule
